// File: rtl/axi4l_rr_arbiter_if.sv
// AXI4-Lite bundle used on both sides of the round-robin arbiter.
// 32-bit address and data; protection signals are not carried.
interface axi4l_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid,
      output bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid,
      input  bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4l_rr_arbiter.sv
// Round-robin arbiter: N AXI4-Lite masters share one slave port,
// one complete transaction at a time.
module axi4l_rr_arbiter #(
   parameter int   N           = 3,
   parameter logic WRITE_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   axi4l_if.slave       axis [N],
   axi4l_if.master      axim,
   output logic [N-1:0] grant,
   output logic         busy
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD      = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;

   logic [2:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] idx;
   logic [IW-1:0] pick;
   logic          found;
   logic          aw_done;
   logic          w_done;

   logic [N-1:0]  awv, wv, arv, brdy, rrdy, req;
   logic [31:0]   awaddr_a [N];
   logic [31:0]   wdata_a  [N];
   logic [3:0]    wstrb_a  [N];
   logic [31:0]   araddr_a [N];

   logic in_wr, in_wresp, in_rd, in_rresp;
   logic aw_fwd, w_fwd, ar_fwd;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

   assign in_wr    = (state == WR);
   assign in_wresp = (state == WR_RESP);
   assign in_rd    = (state == RD);
   assign in_rresp = (state == RD_RESP);

   for (genvar i = 0; i < N; i++) begin : g_up
      assign awv[i]      = axis[i].awvalid;
      assign wv[i]       = axis[i].wvalid;
      assign arv[i]      = axis[i].arvalid;
      assign brdy[i]     = axis[i].bready;
      assign rrdy[i]     = axis[i].rready;
      assign awaddr_a[i] = axis[i].awaddr;
      assign wdata_a[i]  = axis[i].wdata;
      assign wstrb_a[i]  = axis[i].wstrb;
      assign araddr_a[i] = axis[i].araddr;

      // grant is only non-zero outside IDLE, so it alone isolates losers
      assign axis[i].awready = grant[i] & in_wr & ~aw_done & axim.awready;
      assign axis[i].wready  = grant[i] & in_wr & ~w_done & axim.wready;
      assign axis[i].bvalid  = grant[i] & in_wresp & axim.bvalid;
      assign axis[i].bresp   = axim.bresp;
      assign axis[i].arready = grant[i] & in_rd & axim.arready;
      assign axis[i].rvalid  = grant[i] & in_rresp & axim.rvalid;
      assign axis[i].rdata   = axim.rdata;
      assign axis[i].rresp   = axim.rresp;
   end

   assign req = awv | arv;

   always_comb begin
      int j;
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[IW'(j)]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   assign aw_fwd = in_wr & ~aw_done & awv[idx];
   assign w_fwd  = in_wr & ~w_done & wv[idx];
   assign ar_fwd = in_rd & arv[idx];

   assign axim.awvalid = aw_fwd;
   assign axim.awaddr  = awaddr_a[idx];
   assign axim.wvalid  = w_fwd;
   assign axim.wdata   = wdata_a[idx];
   assign axim.wstrb   = wstrb_a[idx];
   assign axim.bready  = in_wresp & brdy[idx];
   assign axim.arvalid = ar_fwd;
   assign axim.araddr  = araddr_a[idx];
   assign axim.rready  = in_rresp & rrdy[idx];

   assign aw_hs = aw_fwd & axim.awready;
   assign w_hs  = w_fwd & axim.wready;
   assign ar_hs = ar_fwd & axim.arready;
   assign b_hs  = axim.bready & axim.bvalid;
   assign r_hs  = axim.rready & axim.rvalid;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= IW'(N-1);
         idx     <= '0;
         grant   <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  idx   <= pick;
                  grant <= ONE << pick;
                  if (awv[pick] && (WRITE_FIRST || !arv[pick]))
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            WR: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               if ((aw_done || aw_hs) && (w_done || w_hs))
                  state <= WR_RESP;
            end
            WR_RESP: begin
               if (b_hs) begin
                  ptr     <= idx;
                  grant   <= '0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= IDLE;
               end
            end
            RD: begin
               if (ar_hs) state <= RD_RESP;
            end
            RD_RESP: begin
               if (r_hs) begin
                  ptr   <= idx;
                  grant <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi4l_rr_arbiter.sv
// Randomized bench for axi4l_rr_arbiter with a transaction-level
// arbitration model, randomized masters and a randomized slave.
module tb_axi4l_rr_arbiter;
   localparam int N   = 3;
   localparam int CYC = 4000;
   localparam bit WF  = 1'b1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] grant;
   logic         busy;

   axi4l_if m [N] ();
   axi4l_if s ();

   axi4l_rr_arbiter #(.N(N), .WRITE_FIRST(WF)) dut (
      .clk(clk), .rst(rst), .axis(m), .axim(s),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   logic        aw_v [N], w_v [N], ar_v [N], b_r [N], r_r [N];
   logic [31:0] aw_a [N], w_d [N], ar_a [N];
   logic [3:0]  w_s  [N];
   logic        aw_rdy [N], w_rdy [N], ar_rdy [N], b_v [N], r_v [N];
   logic [1:0]  b_rs [N], r_rs [N];
   logic [31:0] r_d  [N];

   for (genvar g = 0; g < N; g++) begin : g_m
      assign m[g].awvalid = aw_v[g];
      assign m[g].awaddr  = aw_a[g];
      assign m[g].wvalid  = w_v[g];
      assign m[g].wdata   = w_d[g];
      assign m[g].wstrb   = w_s[g];
      assign m[g].bready  = b_r[g];
      assign m[g].arvalid = ar_v[g];
      assign m[g].araddr  = ar_a[g];
      assign m[g].rready  = r_r[g];
      assign aw_rdy[g]    = m[g].awready;
      assign w_rdy[g]     = m[g].wready;
      assign ar_rdy[g]    = m[g].arready;
      assign b_v[g]       = m[g].bvalid;
      assign b_rs[g]      = m[g].bresp;
      assign r_v[g]       = m[g].rvalid;
      assign r_rs[g]      = m[g].rresp;
      assign r_d[g]       = m[g].rdata;
   end

   int vecs = 0;
   int errs = 0;

   // master models
   bit wr_act [N], aw_p [N], w_p [N], rd_act [N], ar_p [N];
   int w_dly [N];
   // slave model
   bit s_awg, s_wg, s_bv, s_arg, s_rv;
   int s_bd, s_rd;
   logic [31:0] s_la, s_ld, s_lra, s_rdat;
   logic [1:0]  s_brsp, s_rrsp;
   // arbitration model
   bit m_busy, m_wr, m_awd, m_wd, m_ard;
   int m_own, m_last;
   logic [N-1:0] aw_prev, ar_prev;
   // handshakes seen in the previous cycle
   bit h_maw [N], h_mw [N], h_mb [N], h_mar [N], h_mr [N];
   bit h_saw, h_sw, h_sb, h_sar, h_sr;
   bit rst_done;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_data(input logic [31:0] a);
      return a ^ 32'h5A5A_F00F;
   endfunction

   function automatic logic [1:0] rd_resp(input logic [31:0] a);
      return a[3:2];
   endfunction

   function automatic logic [1:0] wr_resp(input logic [31:0] a,
                                          input logic [31:0] d);
      return a[3:2] ^ d[1:0];
   endfunction

   function automatic int winner(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (last + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [4:0] dn_vec();
      return {s.awvalid, s.wvalid, s.arvalid, s.bready, s.rready};
   endfunction

   function automatic logic [5*N-1:0] up_vec();
      logic [5*N-1:0] v;
      for (int i = 0; i < N; i++)
         v[5*i +: 5] = {aw_rdy[i], w_rdy[i], ar_rdy[i], b_v[i], r_v[i]};
      return v;
   endfunction

   task automatic clear_hs();
      for (int i = 0; i < N; i++) begin
         h_maw[i] = 0; h_mw[i] = 0; h_mb[i] = 0;
         h_mar[i] = 0; h_mr[i] = 0;
      end
      h_saw = 0; h_sw = 0; h_sb = 0; h_sar = 0; h_sr = 0;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         wr_act[i] = 0; aw_p[i] = 0; w_p[i] = 0;
         rd_act[i] = 0; ar_p[i] = 0; w_dly[i] = 0;
         b_r[i] = 0; r_r[i] = 0;
         aw_a[i] = '0; w_d[i] = '0; w_s[i] = '0; ar_a[i] = '0;
      end
      s_awg = 0; s_wg = 0; s_bv = 0; s_arg = 0; s_rv = 0;
      s_bd = 0; s_rd = 0;
      s_la = '0; s_ld = '0; s_lra = '0; s_rdat = '0;
      s_brsp = '0; s_rrsp = '0;
      s.awready = 0; s.wready = 0; s.arready = 0;
      m_busy = 0; m_wr = 0; m_awd = 0; m_wd = 0; m_ard = 0;
      m_own = 0; m_last = N - 1;
      clear_hs();
   endtask

   task automatic start_rd(input int i);
      rd_act[i] = 1;
      ar_p[i]   = 1;
      ar_a[i]   = {4'(i + 9), 28'($urandom)};
   endtask

   task automatic apply();
      logic [N-1:0] eg;
      if (!m_busy) begin
         if ((aw_prev | ar_prev) != '0) begin
            m_own  = winner(aw_prev | ar_prev, m_last);
            m_busy = 1;
            m_wr   = aw_prev[m_own] && (WF || !ar_prev[m_own]);
            m_awd  = 0; m_wd = 0; m_ard = 0;
         end
      end else begin
         if (h_saw) m_awd = 1;
         if (h_sw)  m_wd  = 1;
         if (h_sar) m_ard = 1;
         if ((m_wr && h_sb) || (!m_wr && h_sr)) begin
            m_busy = 0;
            m_last = m_own;
         end
      end
      eg = '0;
      if (m_busy) eg[m_own] = 1'b1;
      chk("grant", grant, eg);
      chk("busy", busy, m_busy);

      for (int i = 0; i < N; i++) begin
         if (h_maw[i]) aw_p[i] = 0;
         if (h_mw[i])  w_p[i]  = 0;
         if (h_mb[i])  wr_act[i] = 0;
         if (h_mar[i]) ar_p[i] = 0;
         if (h_mr[i])  rd_act[i] = 0;
         if (w_dly[i] > 0) w_dly[i]--;
      end

      if (h_saw) s_awg = 1;
      if (h_sw)  s_wg  = 1;
      if (h_sb) begin
         s_bv = 0; s_awg = 0; s_wg = 0;
      end else if (s_awg && s_wg && !s_bv) begin
         if (s_bd == 0) begin
            s_bv   = 1;
            s_brsp = wr_resp(s_la, s_ld);
         end else s_bd--;
      end
      if (h_sar) s_arg = 1;
      if (h_sr) begin
         s_rv = 0; s_arg = 0;
      end else if (s_arg && !s_rv) begin
         if (s_rd == 0) begin
            s_rv   = 1;
            s_rdat = rd_data(s_lra);
            s_rrsp = rd_resp(s_lra);
         end else s_rd--;
      end
   endtask

   task automatic stimulus(input int rate);
      for (int i = 0; i < N; i++) begin
         if (!wr_act[i] && $urandom_range(0, 99) < rate) begin
            wr_act[i] = 1; aw_p[i] = 1; w_p[i] = 1;
            w_dly[i]  = $urandom_range(0, 3);
            aw_a[i]   = {4'(i + 1), 28'($urandom)};
            w_d[i]    = $urandom;
            w_s[i]    = 4'($urandom);
         end
         if (!rd_act[i] && $urandom_range(0, 99) < rate) start_rd(i);
         b_r[i] = ($urandom_range(0, 3) != 0);
         r_r[i] = ($urandom_range(0, 3) != 0);
      end
      s.awready = ($urandom_range(0, 2) == 0);
      s.wready  = ($urandom_range(0, 2) == 0);
      s.arready = ($urandom_range(0, 2) == 0);
   endtask

   task automatic drive_in();
      for (int i = 0; i < N; i++) begin
         aw_v[i] = aw_p[i];
         w_v[i]  = w_p[i] && (w_dly[i] == 0);
         ar_v[i] = ar_p[i];
      end
      s.bvalid = s_bv;
      s.bresp  = s_brsp;
      s.rvalid = s_rv;
      s.rdata  = s_rdat;
      s.rresp  = s_rrsp;
   endtask

   task automatic sample();
      int own;
      bit wp, rp;
      logic [5*N-1:0] eu;
      own = m_busy ? m_own : 0;
      wp  = m_busy && m_wr;
      rp  = m_busy && !m_wr;
      for (int i = 0; i < N; i++) begin
         h_maw[i] = aw_v[i] && aw_rdy[i];
         h_mw[i]  = w_v[i] && w_rdy[i];
         h_mar[i] = ar_v[i] && ar_rdy[i];
         h_mb[i]  = b_v[i] && b_r[i];
         h_mr[i]  = r_v[i] && r_r[i];
      end
      h_saw = s.awvalid && s.awready;
      h_sw  = s.wvalid && s.wready;
      h_sar = s.arvalid && s.arready;
      h_sb  = s.bvalid && s.bready;
      h_sr  = s.rvalid && s.rready;

      chk("dn_ctl", dn_vec(),
          {wp && !m_awd && aw_v[own], wp && !m_wd && w_v[own],
           rp && !m_ard && ar_v[own], wp && m_awd && m_wd && b_r[own],
           rp && m_ard && r_r[own]});
      eu = '0;
      if (m_busy)
         eu[5*own +: 5] = {wp && !m_awd && s.awready,
                           wp && !m_wd && s.wready,
                           rp && !m_ard && s.arready,
                           wp && m_awd && m_wd && s.bvalid,
                           rp && m_ard && s.rvalid};
      chk("up_ctl", up_vec(), eu);

      if (h_saw) begin
         chk("aw_once", {s_awg, s_arg}, 2'b00);
         chk("awaddr", s.awaddr, aw_a[own]);
         s_la = s.awaddr;
         s_bd = $urandom_range(0, 3);
      end
      if (h_sw) begin
         chk("w_once", {s_wg, s_arg}, 2'b00);
         chk("wdata", {s.wstrb, s.wdata}, {w_s[own], w_d[own]});
         s_ld = s.wdata;
      end
      if (h_sar) begin
         chk("ar_once", {s_awg, s_wg, s_arg}, 3'b000);
         chk("araddr", s.araddr, ar_a[own]);
         s_lra = s.araddr;
         s_rd  = $urandom_range(0, 3);
      end
      for (int i = 0; i < N; i++) begin
         if (h_mb[i])
            chk("bresp", b_rs[i], wr_resp(aw_a[i], w_d[i]));
         if (h_mr[i])
            chk("rdata", {r_rs[i], r_d[i]},
                {rd_resp(ar_a[i]), rd_data(ar_a[i])});
      end
   endtask

   initial begin
      rst_done = 0;
      clear_all();
      drive_in();
      aw_prev = '0;
      ar_prev = '0;
      for (int cyc = 0; cyc < CYC; cyc++) begin
         @(posedge clk);
         #1;
         if (rst) begin
            rst = 0;
            chk("rst_grant", grant, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_dn", dn_vec(), '0);
            chk("rst_up", up_vec(), '0);
            clear_all();
            // everyone asks at once right after reset: master 0 must win
            for (int i = 0; i < N; i++) start_rd(i);
         end else begin
            apply();
            if (!rst_done && cyc >= 1500 && m_busy && !m_wr &&
                m_ard && s_rv) begin
               rst      = 1;
               rst_done = 1;
            end else begin
               stimulus(((cyc / 500) % 2 == 1) ? 10 : 60);
            end
         end
         drive_in();
         #1;
         if (rst) clear_hs();
         else sample();
         for (int i = 0; i < N; i++) begin
            aw_prev[i] = aw_v[i];
            ar_prev[i] = ar_v[i];
         end
      end
      chk("rst_hit", rst_done, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
